// File: rtl/interp_pilot_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : interp_pilot_seq
// Brief    : Sequential linear interpolator. Captures four pilot estimates
//            E1..E4 and streams 13 quarter-spaced samples (E1 .. E4
//            inclusive) over a valid/ready handshake. Weighted sums use
//            shift-and-add only.
// Options  : INTERP_ROUND_EN - when defined, add 2 before the final >>>2
//            (round half toward +inf); otherwise plain truncation.
// Revision : 1.0 - initial release
// ============================================================================
module interp_pilot_seq #(
  parameter int WIDTH = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] E1,
  input  logic signed [WIDTH-1:0] E2,
  input  logic signed [WIDTH-1:0] E3,
  input  logic signed [WIDTH-1:0] E4,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [3:0]              out_idx,
  output logic                    out_last
);

  // Sum width: 4 * |min pilot| needs two extra magnitude bits plus headroom
  // for the rounding constant.
  localparam int SW = WIDTH + 3;

`ifdef INTERP_ROUND_EN
  localparam logic signed [SW-1:0] c_ROUND_ADD = SW'(2);
`else
  localparam logic signed [SW-1:0] c_ROUND_ADD = SW'(0);
`endif

  localparam logic [3:0] c_LAST_IDX = 4'd12;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic                    w_in_xfer;
  logic                    w_out_xfer;

  logic signed [WIDTH-1:0] r_pa;
  logic signed [WIDTH-1:0] r_pb;
  logic signed [WIDTH-1:0] r_pc;
  logic signed [WIDTH-1:0] r_pd;

  logic signed [WIDTH-1:0] r_data;
  logic [3:0]              r_idx;
  logic                    r_last;

  logic [3:0]              w_nidx;
  logic [1:0]              w_pair;
  logic [1:0]              w_k;
  logic signed [WIDTH-1:0] w_ea;
  logic signed [WIDTH-1:0] w_eb;
  logic signed [SW-1:0]    w_ea_ext;
  logic signed [SW-1:0]    w_eb_ext;
  logic signed [SW-1:0]    w_wa;
  logic signed [SW-1:0]    w_wb;
  logic signed [SW-1:0]    w_sum;
  logic signed [WIDTH-1:0] w_sample;
  logic                    w_unused_bits;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state, handshake strobes and state-derived outputs
  always_comb begin
    w_next_state = r_state;
    w_in_xfer    = 1'b0;
    w_out_xfer   = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_in_xfer    = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_out_xfer = 1'b1;
          if (r_last) begin
            w_next_state = ST_IDLE;
          end
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Index of the sample that will be loaded on the next output transfer.
  assign w_nidx = r_idx + 4'd1;
  assign w_pair = w_nidx[3:2];
  assign w_k    = w_nidx[1:0];

  // Select the pilot pair; pair 3 only occurs at n = 12 (k = 0), where the
  // result is pd alone.
  always_comb begin
    w_ea = r_pa;
    w_eb = r_pb;
    case (w_pair)
      2'd0: begin
        w_ea = r_pa;
        w_eb = r_pb;
      end
      2'd1: begin
        w_ea = r_pb;
        w_eb = r_pc;
      end
      2'd2: begin
        w_ea = r_pc;
        w_eb = r_pd;
      end
      default: begin
        w_ea = r_pd;
        w_eb = r_pd;
      end
    endcase
  end

  assign w_ea_ext = {{(SW-WIDTH){w_ea[WIDTH-1]}}, w_ea};
  assign w_eb_ext = {{(SW-WIDTH){w_eb[WIDTH-1]}}, w_eb};

  // Weights (4-k) on Ea and k on Eb, built from shifts and adds only
  always_comb begin
    w_wa = w_ea_ext <<< 2;
    w_wb = '0;
    case (w_k)
      2'd0: begin
        w_wa = w_ea_ext <<< 2;
        w_wb = '0;
      end
      2'd1: begin
        w_wa = (w_ea_ext <<< 1) + w_ea_ext;
        w_wb = w_eb_ext;
      end
      2'd2: begin
        w_wa = w_ea_ext <<< 1;
        w_wb = w_eb_ext <<< 1;
      end
      default: begin
        w_wa = w_ea_ext;
        w_wb = (w_eb_ext <<< 1) + w_eb_ext;
      end
    endcase
  end

  // Divide by 4 with an arithmetic shift; the quotient always fits WIDTH bits.
  assign w_sum         = w_wa + w_wb + c_ROUND_ADD;
  assign w_sample      = w_sum[WIDTH+1:2];
  assign w_unused_bits = ^{w_sum[SW-1], w_sum[1:0]};

  // Pilot capture and registered output sample / index / last flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pa   <= '0;
      r_pb   <= '0;
      r_pc   <= '0;
      r_pd   <= '0;
      r_data <= '0;
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (w_in_xfer) begin
      r_pa   <= E1;
      r_pb   <= E2;
      r_pc   <= E3;
      r_pd   <= E4;
      // Sample 0 is (4*E1 + R) >>> 2 which equals E1 exactly for R in {0,2}.
      r_data <= E1;
      r_idx  <= '0;
      r_last <= 1'b0;
    end else if (w_out_xfer) begin
      if (r_last) begin
        r_idx  <= '0;
        r_last <= 1'b0;
      end else begin
        r_data <= w_sample;
        r_idx  <= w_nidx;
        r_last <= (w_nidx == c_LAST_IDX);
      end
    end
  end

  assign out_data = r_data;
  assign out_idx  = r_idx;
  assign out_last = r_last;

endmodule
`default_nettype wire

// File: tb/tb_interp_pilot_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_interp_pilot_seq
// Brief    : Directed, table-driven bench for interp_pilot_seq with extra
//            sequences for backpressure, mid-run reset and back-to-back sets.
// Revision : 1.0 - initial release
// ============================================================================
module tb_interp_pilot_seq;

  localparam int WIDTH = 17;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] E1, E2, E3, E4;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic [3:0]              out_idx;
  logic                    out_last;

  interp_pilot_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .E1        (E1),
    .E2        (E2),
    .E3        (E3),
    .E4        (E4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0]        e1;
    logic [WIDTH-1:0]        e2;
    logic [WIDTH-1:0]        e3;
    logic [WIDTH-1:0]        e4;
    logic [12:0][WIDTH-1:0]  exp;
  } vec_t;

  localparam int NVEC = 5;
  vec_t vecs [NVEC];
  int   t [13];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load_vec(input int i, input int a, input int b, input int c, input int d);
    vecs[i].e1 = 17'(a);
    vecs[i].e2 = 17'(b);
    vecs[i].e3 = 17'(c);
    vecs[i].e4 = 17'(d);
    for (int j = 0; j < 13; j++) vecs[i].exp[j] = 17'(t[j]);
  endtask

  function automatic int expv(input vec_t v, input int j);
    return int'($signed(v.exp[j]));
  endfunction

  // Check the 13 samples of vector v, one per negedge, out_ready held high.
  task automatic check_stream(input vec_t v, input string tag);
    for (int j = 0; j < 13; j++) begin
      @(negedge clk);
      chk($sformatf("%s valid[%0d]", tag, j), int'(out_valid), 1);
      chk($sformatf("%s data[%0d]", tag, j), int'($signed(out_data)), expv(v, j));
      chk($sformatf("%s idx[%0d]", tag, j), int'(out_idx), j);
      chk($sformatf("%s last[%0d]", tag, j), int'(out_last), (j == 12) ? 1 : 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    chk({tag, " in_ready idle"}, int'(in_ready), 1);
    E1 = $signed(v.e1); E2 = $signed(v.e2); E3 = $signed(v.e3); E4 = $signed(v.e4);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_stream(v, tag);
    @(negedge clk);
    chk({tag, " in_ready after"}, int'(in_ready), 1);
    chk({tag, " out_valid after"}, int'(out_valid), 0);
  endtask

  initial begin
    // ---------------- vector table ----------------
    t = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    load_vec(0, 0, 4, 8, 12);
`ifdef INTERP_ROUND_EN
    t = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`else
    t = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
`endif
    load_vec(1, 0, 1, 1, 1);
    t = '{-4, -2, 0, 2, 4, 2, 0, -2, -4, -2, 0, 2, 4};
    load_vec(2, -4, 4, -4, 4);
`ifdef INTERP_ROUND_EN
    t = '{-65536, -32768, 0, 32767, 65535, 32767, 0, -32768, -65536, -32768, 0, 32767, 65535};
`else
    t = '{-65536, -32769, -1, 32767, 65535, 32767, -1, -32769, -65536, -32769, -1, 32767, 65535};
`endif
    load_vec(3, -65536, 65535, -65536, 65535);
`ifdef INTERP_ROUND_EN
    t = '{100, 70, 40, 10, -20, -13, -6, 0, 7, 5, 4, 2, 0};
`else
    t = '{100, 70, 40, 10, -20, -14, -7, 0, 7, 5, 3, 1, 0};
`endif
    load_vec(4, 100, -20, 7, 0);

    // ---------------- reset state ----------------
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    E1 = '0; E2 = '0; E3 = '0; E4 = '0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_data", int'($signed(out_data)), 0);
    chk("reset out_idx", int'(out_idx), 0);
    chk("reset out_last", int'(out_last), 0);
    rst = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // ---------------- backpressure ----------------
    begin
      int cnt;
      int cyc;
      int stall;
      cnt = 0; cyc = 0; stall = 0;
      @(negedge clk);
      E1 = $signed(vecs[0].e1); E2 = $signed(vecs[0].e2);
      E3 = $signed(vecs[0].e3); E4 = $signed(vecs[0].e4);
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      // Offer a different set throughout RUN; it must be ignored.
      E1 = 17'sd500; E2 = -17'sd500; E3 = 17'sd300; E4 = 17'sd1;
      while (cnt < 13 && cyc < 300) begin
        @(negedge clk);
        cyc++;
        chk($sformatf("bp valid[%0d]", cnt), int'(out_valid), 1);
        chk($sformatf("bp in_ready[%0d]", cnt), int'(in_ready), 0);
        chk($sformatf("bp idx[%0d]", cnt), int'(out_idx), cnt);
        chk($sformatf("bp data[%0d]", cnt), int'($signed(out_data)), expv(vecs[0], cnt));
        chk($sformatf("bp last[%0d]", cnt), int'(out_last), (cnt == 12) ? 1 : 0);
        if (cnt == 12) in_valid = 1'b0;
        if (cnt == 6 && stall < 5) begin
          out_ready = 1'b0;
          stall++;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk);
        if (out_ready) cnt++;
      end
      chk("bp transfers", cnt, 13);
      chk("bp stall cycles", stall, 5);
      @(negedge clk);
      chk("bp in_ready after", int'(in_ready), 1);
      chk("bp out_valid after", int'(out_valid), 0);
    end

    // ---------------- reset mid-run ----------------
    @(negedge clk);
    E1 = $signed(vecs[4].e1); E2 = $signed(vecs[4].e2);
    E3 = $signed(vecs[4].e3); E4 = $signed(vecs[4].e4);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid idx before rst", int'(out_idx), 7);
    rst = 1'b1;
    #1;
    chk("mid rst out_valid", int'(out_valid), 0);
    chk("mid rst out_idx", int'(out_idx), 0);
    chk("mid rst in_ready", int'(in_ready), 1);
    chk("mid rst out_data", int'($signed(out_data)), 0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(vecs[0], "post-rst");

    // ---------------- back-to-back ----------------
    @(negedge clk);
    E1 = $signed(vecs[0].e1); E2 = $signed(vecs[0].e2);
    E3 = $signed(vecs[0].e3); E4 = $signed(vecs[0].e4);
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    E1 = $signed(vecs[4].e1); E2 = $signed(vecs[4].e2);
    E3 = $signed(vecs[4].e3); E4 = $signed(vecs[4].e4);
    check_stream(vecs[0], "b2b A");
    @(negedge clk);
    chk("b2b gap in_ready", int'(in_ready), 1);
    chk("b2b gap out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_stream(vecs[4], "b2b B");
    @(negedge clk);
    chk("b2b end in_ready", int'(in_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
